// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,
    REQ_WR  = 2'd1,
    REQ_BAD = 2'd2
  } dmem_kind_e;

  // Byte address -> word index: the low bits must be zero for an aligned word.
  localparam int unsigned ALIGN_BITS = 2;
  localparam logic [1:0]  ALIGN_ZERO = 2'b00;

endpackage

// File: rtl/dmem_if.sv
// Load/store handshake between the core (master) and the data memory (slave).
interface dmem_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  memread;
  logic                  memwrite;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;
  logic                  busy;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: clocked write, combinational read of the same address.
module dmem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

  // Word write on the clock edge; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// then pulses ready (and err on a bad request) for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic  clk,
  input  logic  arst,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [DATA_WIDTH-1:0] DEPTH_LIMIT = DATA_WIDTH'(DEPTH_WORDS);

  dmem_state_e           state_r;
  dmem_state_e           state_nx_s;
  dmem_kind_e            kind_r;
  dmem_kind_e            kind_live_s;
  dmem_kind_e            resp_kind_s;
  logic [3:0]            cnt_r;
  logic [AW-1:0]         idx_r;
  logic [AW-1:0]         ram_addr_s;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  ready_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  req_s;
  logic                  ram_we_s;

  function automatic dmem_kind_e classify(input logic [DATA_WIDTH-1:0] a,
                                          input logic rd, input logic wr);
    dmem_kind_e k;
    if ((rd && wr) || (a[ALIGN_BITS-1:0] != ALIGN_ZERO) ||
        ((a >> ALIGN_BITS) >= DEPTH_LIMIT)) begin
      k = REQ_BAD;
    end else if (wr) begin
      k = REQ_WR;
    end else begin
      k = REQ_RD;
    end
    return k;
  endfunction

  assign req_s       = bus.memread | bus.memwrite;
  assign kind_live_s = classify(bus.addr, bus.memread, bus.memwrite);

  // In IDLE the live request is steered to the RAM so a zero-wait read
  // can be registered on the acceptance edge itself.
  always_comb begin
    ram_addr_s  = idx_r;
    resp_kind_s = kind_r;
    if (state_r == IDLE) begin
      ram_addr_s  = bus.addr[AW+ALIGN_BITS-1:ALIGN_BITS];
      resp_kind_s = kind_live_s;
    end else begin
      ram_addr_s  = idx_r;
      resp_kind_s = kind_r;
    end
  end

  assign ram_we_s = (state_r == RESP) && (kind_r == REQ_WR);

  // Next-state decode for the request FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nx_s = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, captured request, wait counter and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= IDLE;
      kind_r  <= REQ_RD;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      ready_r <= (state_nx_s == RESP);
      err_r   <= (state_nx_s == RESP) && (resp_kind_s == REQ_BAD);

      if (state_nx_s == RESP) begin
        if (resp_kind_s == REQ_BAD) begin
          rdata_r <= '0;
        end else if (resp_kind_s == REQ_RD) begin
          rdata_r <= ram_rdata_s;
        end else begin
          rdata_r <= rdata_r;
        end
      end

      if ((state_r == IDLE) && req_s) begin
        idx_r   <= bus.addr[AW+ALIGN_BITS-1:ALIGN_BITS];
        wdata_r <= bus.wdata;
        kind_r  <= kind_live_s;
        cnt_r   <= WS_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  dmem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven with directed
// transactions; monitors pop expected responses on every ready pulse.
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q2[$];
  exp_t q0[$];
  exp_t e2;
  exp_t e0;
  logic [31:0] last2 = 32'h0;
  logic [31:0] last0 = 32'h0;
  logic [31:0] fib_tab [13] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
                                32'd13, 32'd21, 32'd34, 32'd55, 32'd89, 32'd144};

  always #5 clk = ~clk;

  dmem_if #(.DATA_WIDTH(32)) bus2 ();
  dmem_if #(.DATA_WIDTH(32)) bus0 ();

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
    .clk (clk), .arst (arst), .bus (bus2)
  );
  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk (clk), .arst (arst), .bus (bus0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input int ws, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (ws == 2) begin
      bus2.memread = rd; bus2.memwrite = wr; bus2.addr = a; bus2.wdata = d;
    end else begin
      bus0.memread = rd; bus0.memwrite = wr; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  function automatic logic get_ready(input int ws);
    return (ws == 2) ? bus2.ready : bus0.ready;
  endfunction

  function automatic logic get_busy(input int ws);
    return (ws == 2) ? bus2.busy : bus0.busy;
  endfunction

  // One transaction: exp_word is the hand-computed load value for reads.
  task automatic txn(input int ws, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_word,
                     input bit scramble);
    exp_t e;
    int   lat;
    int   busy_n;
    bit   got;
    @(negedge clk);
    check($sformatf("ws%0d_idle_busy", ws), {31'd0, get_busy(ws)}, 32'd0);
    e.err   = exp_err;
    e.rdata = exp_err ? 32'h0 : (rd ? exp_word : ((ws == 2) ? last2 : last0));
    if (ws == 2) begin
      q2.push_back(e);
      if (exp_err || rd) last2 = e.rdata;
    end else begin
      q0.push_back(e);
      if (exp_err || rd) last0 = e.rdata;
    end
    drive(ws, rd, wr, a, d);
    @(posedge clk);
    lat = 0; busy_n = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (get_busy(ws)) busy_n++;
      if (scramble && lat == 1) drive(ws, rd, wr, 32'h80, 32'hBAD0_BAD0);
      if (get_ready(ws)) got = 1'b1;
    end
    drive(ws, 1'b0, 1'b0, 32'h0, 32'h0);
    check($sformatf("ws%0d_latency_a%0h", ws, a), lat, ws + 1);
    check($sformatf("ws%0d_busy_cycles_a%0h", ws, a), busy_n, ws + 1);
  endtask

  // Scoreboard monitor for the two-wait-state instance.
  always @(negedge clk) begin
    if (!arst && bus2.ready) begin
      if (q2.size() == 0) begin
        check("ws2_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("ws2_err", {31'd0, bus2.err}, {31'd0, e2.err});
        check("ws2_rdata", bus2.rdata, e2.rdata);
      end
    end
    if (bus2.err && !bus2.ready) check("ws2_err_without_ready", 32'd1, 32'd0);
  end

  // Scoreboard monitor for the zero-wait-state instance.
  always @(negedge clk) begin
    if (!arst && bus0.ready) begin
      if (q0.size() == 0) begin
        check("ws0_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("ws0_err", {31'd0, bus0.err}, {31'd0, e0.err});
        check("ws0_rdata", bus0.rdata, e0.rdata);
      end
    end
    if (bus0.err && !bus0.ready) check("ws0_err_without_ready", 32'd1, 32'd0);
  end

  initial begin
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus2.ready}, 32'd0);
    check("rst_err", {31'd0, bus2.err}, 32'd0);
    check("rst_busy", {31'd0, bus2.busy}, 32'd0);
    check("rst_rdata", bus2.rdata, 32'h0);
    check("rst0_ready", {31'd0, bus0.ready}, 32'd0);
    check("rst0_rdata", bus0.rdata, 32'h0);
    arst = 1'b0;

    // Known value at 0x10, then abort an overwrite with reset mid-WAIT.
    txn(2, 1'b0, 1'b1, 32'h10, 32'h0000_00AA, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_in_wait", {31'd0, bus2.busy}, 32'd1);
    arst = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus2.ready}, 32'd0);
    check("abort_err", {31'd0, bus2.err}, 32'd0);
    check("abort_busy", {31'd0, bus2.busy}, 32'd0);
    check("abort_rdata", bus2.rdata, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    last2 = 32'h0;
    txn(2, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_00AA, 1'b0);

    // Round trip, misaligned, out of range, both-high.
    txn(2, 1'b0, 1'b1, 32'h08, 32'h0000_0037, 1'b0, 32'h0, 1'b0);
    txn(2, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0000_0037, 1'b0);
    txn(2, 1'b0, 1'b1, 32'h04, 32'h5A5A_0004, 1'b0, 32'h0, 1'b0);
    txn(2, 1'b0, 1'b1, 32'h06, 32'h1111_2222, 1'b1, 32'h0, 1'b0);
    txn(2, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h5A5A_0004, 1'b0);
    txn(2, 1'b1, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(2, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(2, 1'b1, 1'b1, 32'h08, 32'h0000_FFFF, 1'b1, 32'h0, 1'b0);
    txn(2, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0000_0037, 1'b0);

    // Fibonacci sweep; entry 5 has its address changed during WAIT.
    txn(2, 1'b0, 1'b1, 32'h80, 32'h8080_8080, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      txn(2, 1'b0, 1'b1, 32'(4 * i), fib_tab[i], 1'b0, 32'h0, (i == 5));
    end
    for (int i = 0; i < 13; i++) begin
      txn(2, 1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b0, fib_tab[i], 1'b0);
    end
    txn(2, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h8080_8080, 1'b0);

    // Zero wait states: back-to-back, misaligned, last valid word.
    txn(0, 1'b0, 1'b1, 32'h04, 32'h0000_0015, 1'b0, 32'h0, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0000_0015, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1'b0);
    txn(0, 1'b0, 1'b1, 32'h3FC, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0000_0077, 1'b0);

    repeat (4) @(negedge clk);
    check("ws2_queue_drained", q2.size(), 32'd0);
    check("ws0_queue_drained", q0.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the load/store side of microprocessor_top; it answers the core's memread/memwrite requests.
- Holds a word-addressed RAM.
- Inserts a configurable number of wait states and returns a one-cycle ready/err handshake that the core uses as its stall release.
- Also serves as the memory model for the Fibonacci program bench and for formal proofs of the load/store path.

Parameters:
- DATA_WIDTH, 32, word width and address width (address driven from alu_result).
- DEPTH_WORDS, 256, number of RAM words; must be a power of two, at least 4.
- WAIT_STATES, 2, idle cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- arst  input  1  asynchronous, active-high reset.
- memread  input  1  load request; held by core until ready.
- memwrite  input  1  store request; held by core until ready.
- addr  input  DATA_WIDTH  byte address (core alu_result).
- wdata  input  DATA_WIDTH  store data; sampled at acceptance.
- rdata  output  DATA_WIDTH  load data, registered.
- ready  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse, coincident with ready.
- busy  output  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (async assert, sync release): state IDLE; ready=0, err=0, busy=0, rdata=0; wait counter=0. RAM contents are not reset.
- FSM IDLE:
  - memread|memwrite high -> capture addr, wdata and kind (read/write/both).
  - Go to WAIT if WAIT_STATES>0, else RESP.
- FSM WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 go to RESP.
- FSM RESP: ready=1 for exactly this cycle; next state IDLE.
- Latency: ready is asserted WAIT_STATES+1 cycles after the acceptance edge (WAIT_STATES=0 -> ready the cycle after the request).
- Request sampled only in IDLE; addr, wdata and kind are captured there. Input changes during WAIT/RESP are ignored.
- A request still high in the cycle after RESP is a new request. The core must drop it in the ready cycle to avoid a repeat.
- Error conditions, checked on captured values:
  - addr[1:0] != 0 (misaligned);
  - addr[DATA_WIDTH-1:2] >= DEPTH_WORDS (out of range);
  - memread and memwrite both high.
- On error: err=1 with ready, no RAM write, rdata forced to 0.
- Write commit: RAM[addr>>2] <= wdata on the RESP clock edge.
- Read: rdata <= RAM[addr>>2] on entry to RESP, so it is valid while ready=1. rdata holds until the next read or error response; writes do not alter rdata.
- Read-after-write to the same word in back-to-back transactions returns the new data (the write commits before the next acceptance).
- Reset mid-transaction: the transaction is aborted, the pending write is not committed, and ready does not pulse.
- busy = (state != IDLE).

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - request-kind enum {REQ_RD, REQ_WR, REQ_BAD};
  - address-alignment constants.
- One sub-module dmem_array: single-port synchronous RAM, DEPTH_WORDS x DATA_WIDTH, with we/addr/wdata/rdata ports and no reset.
- The FSM and wait counter stay in dmem_responder.

Test Plan:
- Reset values: assert arst mid-WAIT of a write to 0x10 -> ready/err/busy/rdata all 0; after release, a read of 0x10 does not return the aborted wdata.
- Write/read round trip, WAIT_STATES=2:
  - write 0x0000_0037 to addr 0x08 -> ready 3 cycles after acceptance, err=0.
  - read 0x08 -> rdata=0x0000_0037 in its ready cycle.
- Zero wait states, WAIT_STATES=0:
  - back-to-back write 0x15 to 0x04, then read 0x04 -> each ready one cycle after its request;
  - rdata=0x15;
  - busy high exactly one cycle per transaction.
- Misaligned access: write to 0x06 -> err=1 with ready; a subsequent read of 0x04 is unchanged; a read of 0x06 gives err=1, rdata=0.
- Out of range: read of addr 4*DEPTH_WORDS (0x400) -> err=1, rdata=0. Both memread and memwrite high -> err=1, no RAM change.
- Fibonacci sweep: store fib(0..12) at 0x00..0x30, read back -> 0,1,1,2,...,144 in order, err never set. Changing addr during WAIT does not alter the target word.
